// File: rtl/image_stream_reader.sv
// Streams one raster-order image frame out of a 1-cycle-latency BRAM onto a valid/ready pixel stream.
// A 2-deep skid FIFO plus an occupancy-gated read issue absorbs any backpressure without loss.
module image_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 18,
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic [DATA_WIDTH-1:0] pix_data_o,
    output logic                  pix_eol_o,
    output logic                  pix_eof_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CW-1:0]         COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  eol;
        logic                  eof;
    } pix_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic                  inflight_q;
    logic                  infl_eol_q;
    logic                  infl_eof_q;
    pix_t                  fifo_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    logic       pop;
    logic       push;
    logic [2:0] occupancy;
    logic       issue;
    logic       issue_eol;
    logic       issue_eof;
    pix_t       head;

    assign head      = fifo_q[rd_ptr_q];
    assign pop       = (count_q != 2'd0) & pix_ready_i;
    assign push      = inflight_q;
    // Count the read already in flight so the FIFO can never be asked to hold a third word.
    assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == S_RUN) && (occupancy < 3'd2);
    assign issue_eol = (col_q == COL_LAST);
    assign issue_eof = issue_eol && (row_q == ROW_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && issue_eof) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && head.eof) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The final issue rewinds the address instead of stepping past the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q     <= BASE;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            infl_eol_q <= 1'b0;
            infl_eof_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                infl_eol_q <= issue_eol;
                infl_eof_q <= issue_eof;
                if (issue_eof) begin
                    addr_q <= BASE;
                    col_q  <= '0;
                    row_q  <= '0;
                end else begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    if (issue_eol) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= '{data: mem_rd_data_i, eol: infl_eol_q, eof: infl_eof_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(push && !pop && count_q == 2'd2));

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_addr_o  = addr_q;
    assign pix_valid_o = (count_q != 2'd0);
    assign pix_data_o  = head.data;
    assign pix_eol_o   = pix_valid_o & head.eol;
    assign pix_eof_o   = pix_valid_o & head.eof;

endmodule

// File: tb/tb_image_stream_reader.sv
// Directed + randomized-backpressure bench for image_stream_reader: a 4x3 frame at a non-zero base
// and a 1x1 frame, checked against a frame model built from the memory image.
module tb_image_stream_reader;

    localparam int WA = 4, HA = 3, NA = WA * HA, BASE_A = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, ready_a = 1'b1;
    logic       busy_a, done_a, vld_a, eol_a, eof_a;
    logic [7:0] addr_a, rd_a, data_a;
    logic [7:0] mem_a [0:255];

    logic       start_b = 1'b0, ready_b = 1'b1;
    logic       busy_b, done_b, vld_b, eol_b, eof_b;
    logic [3:0] addr_b;
    logic [7:0] rd_b, data_b;
    logic [7:0] mem_b [0:15];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rd_a <= mem_a[addr_a];
    always @(posedge clk) rd_b <= mem_b[addr_b];

    image_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .IMG_WIDTH(WA), .IMG_HEIGHT(HA),
                          .BASE_ADDR(BASE_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .mem_addr_o(addr_a), .mem_rd_data_i(rd_a), .pix_valid_o(vld_a), .pix_ready_i(ready_a),
        .pix_data_o(data_a), .pix_eol_o(eol_a), .pix_eof_o(eof_a));

    image_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .IMG_WIDTH(1), .IMG_HEIGHT(1),
                          .BASE_ADDR(7)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .mem_addr_o(addr_b), .mem_rd_data_i(rd_b), .pix_valid_o(vld_b), .pix_ready_i(ready_b),
        .pix_data_o(data_b), .pix_eol_o(eol_b), .pix_eof_o(eof_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready=1, 1: toggling, 2: random, 3: held low 20 cycles after first valid
    task automatic run_frame(input int mode, input bit repulse);
        logic [7:0] exp_d [NA];
        int  t = 1, idx = 0, dones = 0, stall_left = 20;
        bit  seen = 0, hold_pend = 0;
        logic [7:0] hold_d = 0;
        for (int i = 0; i < NA; i++) exp_d[i] = mem_a[BASE_A + i];
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        while (!(dones > 0 && !busy_a) && t < 300) begin
            start_a = repulse && (t == 5);
            chk("addr_range", 32'(addr_a <= 8'(BASE_A + NA - 1)), 1);
            if (hold_pend) begin
                chk("hold_valid", vld_a, 1);
                chk("hold_data", data_a, hold_d);
            end
            if (mode == 0) begin
                chk("busy_timeline", busy_a, (t <= NA + 3));
                chk("done_timeline", done_a, (t == NA + 3));
                chk("valid_timeline", vld_a, (t >= 3 && t <= NA + 2));
            end
            if (done_a) begin
                dones++;
                chk("done_after_all", idx, NA);
            end
            if (vld_a) seen = 1;
            case (mode)
                0:       ready_a = 1'b1;
                1:       ready_a = t[0];
                2:       ready_a = 1'($urandom_range(0, 1));
                default: begin
                    if (seen && stall_left > 0) begin
                        ready_a = 1'b0;
                        stall_left--;
                        chk("stall_two_reads", addr_a, 8'(BASE_A + 2));
                        chk("stall_data", data_a, exp_d[0]);
                    end else begin
                        ready_a = 1'b1;
                        if (seen && idx > 0 && idx < NA) chk("no_gap", vld_a, 1);
                    end
                end
            endcase
            if (vld_a && ready_a) begin
                if (idx < NA) begin
                    chk("pix_data", data_a, exp_d[idx]);
                    chk("pix_eol", eol_a, (idx % WA == WA - 1));
                    chk("pix_eof", eof_a, (idx == NA - 1));
                end else begin
                    chk("extra_pixel", idx, NA - 1);
                end
                idx++;
            end
            hold_pend = vld_a && !ready_a;
            hold_d    = data_a;
            @(negedge clk);
            t++;
        end
        start_a = 1'b0;
        ready_a = 1'b1;
        chk("frame_in_budget", 32'(t < 300), 1);
        chk("pixel_count", idx, NA);
        chk("done_pulses", dones, 1);
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_addr"}, addr_a, BASE_A);
        chk({tag, "_valid"}, vld_a, 0);
        chk({tag, "_data"}, data_a, 0);
        chk({tag, "_eol_eof"}, {eol_a, eof_a}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < NA; i++) mem_a[BASE_A + i] = 8'(i);
        for (int i = 0; i < 16; i++) mem_b[i] = 8'(i * 17);
        mem_b[7] = 8'hA5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_a("reset");
        chk("reset_b_addr", addr_b, 7);
        rst = 1'b0;
        @(negedge clk);

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(3, 0);
        run_frame(0, 1);

        // Asynchronous reset mid-frame, then a clean restart from pixel 0.
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_a("midframe_rst");
        @(negedge clk); rst = 1'b0;
        run_frame(0, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NA; i++) mem_a[BASE_A + i] = 8'($urandom);
            run_frame(2, 0);
        end

        // 1x1 frame at base 7.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            chk("b_busy", busy_b, (t >= 1 && t <= 4));
            chk("b_valid", vld_b, (t == 3));
            chk("b_done", done_b, (t == 4));
            chk("b_addr", addr_b, 7);
            if (t == 3) begin
                chk("b_data", data_b, 8'hA5);
                chk("b_eol_eof", {eol_b, eof_b}, 2'b11);
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
